// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared constants and types for the ARM pipeline fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

  // AL-condition AND R0,R0,R0: harmless filler for unloaded/invalid fetches.
  localparam logic [31:0] NOP_WORD = 32'hE000_0000;

  // Loader controller states.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : Simple dual-port RAM, one synchronous write port and one
//               synchronous (enable-gated) read port. No reset on contents.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one word per cycle from the load stream.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: output register only updates on a read, so it holds on stall.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Loadable instruction memory with streaming load port and a
//               registered, stallable fetch port. Unloaded words read as NOP.
//               Optional macro IMEM_BOUNDS_CHECK_EN enables out-of-program
//               fetch detection with a sticky fetch_fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = arm_pkg::NOP_WORD,
  parameter int                ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              fetch_en,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic              fetch_fault
);

  import arm_pkg::*;

  // Count is one bit wider than the index so it can reach DEPTH.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  imem_state_t       state, state_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] index;
  logic              ld_hs;
  logic              in_prog;
  logic              hit;
  logic              fetch_go;
  logic              use_mem;
  logic [DATA_W-1:0] ram_q;
  logic              unused_pc;

  assign index    = pc[ADDR_W+1:2];
  assign ld_ready = (state == LOAD) && (count < FULL_CNT);
  assign ld_done  = (state == RUN);
  assign ld_hs    = ld_valid && ld_ready;
  assign in_prog  = ({1'b0, index} < count);
  // ld_start beats a simultaneous fetch.
  assign fetch_go = (state == RUN) && fetch_en && !ld_start;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign hit       = in_prog && (pc[31:ADDR_W+2] == '0);
  assign unused_pc = ^pc[1:0];

  // Sticky fault: set by an out-of-program fetch, cleared by a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    fetch_fault <= 1'b0;
    else if (ld_start)          fetch_fault <= 1'b0;
    else if (fetch_go && !hit)  fetch_fault <= 1'b1;
  end
`else
  // Upper pc bits are dropped, so addresses wrap modulo DEPTH.
  assign hit         = in_prog;
  assign unused_pc   = ^{pc[31:ADDR_W+2], pc[1:0]};
  assign fetch_fault = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next state: finish load on ld_last or on filling the memory; reload on ld_start.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (!ld_start && ld_hs && (ld_last || count == LAST_IDX)) state_nxt = RUN;
      RUN:  if (ld_start) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Load word counter; a restart drops any word offered in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (ld_start) count <= '0;
    else if (ld_hs)    count <= count + (ADDR_W + 1)'(1);
  end

  // Fetch qualifiers; forced idle in LOAD, held on stall in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid <= 1'b0;
      use_mem    <= 1'b0;
    end else if (state == RUN && !ld_start) begin
      if (fetch_en) begin
        inst_valid <= 1'b1;
        use_mem    <= hit;
      end
    end else begin
      inst_valid <= 1'b0;
      use_mem    <= 1'b0;
    end
  end

  // RAM output is registered; a miss or idle fetch substitutes the NOP.
  assign instruction = use_mem ? ram_q : NOP_WORD;

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ld_hs && !ld_start),
    .waddr (count[ADDR_W-1:0]),
    .wdata (ld_data),
    .re    (fetch_go),
    .raddr (index),
    .rdata (ram_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_loader
// Description : Self-checking bench for inst_mem_loader (table vectors plus
//               hand-written multi-cycle sequences, scoreboard-based fetches).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 128;
  localparam logic [31:0] NOP    = 32'hE000_0000;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_start, ld_valid, ld_last;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready, ld_done;
  logic              fetch_en;
  logic [31:0]       pc;
  logic [DATA_W-1:0] instruction;
  logic              inst_valid;
  logic              fetch_fault;

  typedef struct {
    logic [31:0] pc;
    bit          en;
    logic [31:0] instr;
    bit          valid;
    bit          fault;   // expected sticky fault when bounds checking is built in
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    bit          valid;
    bit          fault;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   passed = 0;
  int   total  = 0;

  inst_mem_loader #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_last     (ld_last),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Drive one fetch cycle, queue its expected result, compare after the edge.
  task automatic fetch_chk(input logic [31:0] p, input bit en, input logic [31:0] ei,
                           input bit ev, input bit ef);
    exp_t e;
    pc       = p;
    fetch_en = en;
    e.instr  = ei;
    e.valid  = ev;
    e.fault  = ef;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    check($sformatf("instruction pc=%0h", p), instruction, e.instr);
    check($sformatf("inst_valid pc=%0h", p), 32'(inst_valid), 32'(e.valid));
    check($sformatf("fetch_fault pc=%0h", p), 32'(fetch_fault), 32'(e.fault));
    fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'd0,  1'b1, 32'hE3A01014, 1'b1, 1'b0};
    vecs[1] = '{32'd4,  1'b1, 32'hE3A0000C, 1'b1, 1'b0};
    vecs[2] = '{32'd8,  1'b1, 32'hE0030190, 1'b1, 1'b0};
    vecs[3] = '{32'd12, 1'b1, NOP,          1'b1, 1'b1};
    vecs[4] = '{32'd4,  1'b1, 32'hE3A0000C, 1'b1, 1'b1};
    vecs[5] = '{32'd8,  1'b0, 32'hE3A0000C, 1'b1, 1'b1};
    vecs[6] = '{32'd0,  1'b0, 32'hE3A0000C, 1'b1, 1'b1};
    vecs[7] = '{32'd12, 1'b0, 32'hE3A0000C, 1'b1, 1'b1};
    vecs[8] = '{32'd8,  1'b1, 32'hE0030190, 1'b1, 1'b1};
    vecs[9] = '{32'd6,  1'b1, 32'hE3A0000C, 1'b1, 1'b1};

    rst = 1'b1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    fetch_en = 0; pc = '0;
    step(); step();
    rst = 1'b0;
    step();
    check("reset instruction", instruction, NOP);
    check("reset inst_valid", 32'(inst_valid), 32'd0);
    check("reset ld_ready", 32'(ld_ready), 32'd1);
    check("reset ld_done", 32'(ld_done), 32'd0);
    check("reset fetch_fault", 32'(fetch_fault), 32'd0);

    // Three-word program.
    load_word(32'hE3A01014, 1'b0);
    check("ld_done after word0", 32'(ld_done), 32'd0);
    load_word(32'hE3A0000C, 1'b0);
    load_word(32'hE0030190, 1'b1);
    check("ld_done after last", 32'(ld_done), 32'd1);
    check("inst_valid before fetch", 32'(inst_valid), 32'd0);
    check("instruction before fetch", instruction, NOP);

    for (int i = 0; i < 10; i++)
      fetch_chk(vecs[i].pc, vecs[i].en, vecs[i].instr, vecs[i].valid, BOUNDS && vecs[i].fault);

`ifdef IMEM_BOUNDS_CHECK_EN
    fetch_chk(32'd16,        1'b1, NOP,          1'b1, 1'b1);
    fetch_chk(32'h0000_0200, 1'b1, NOP,          1'b1, 1'b1);
    fetch_chk(32'd0,         1'b1, 32'hE3A01014, 1'b1, 1'b1);
`else
    fetch_chk(32'(DEPTH * 4), 1'b1, 32'hE3A01014, 1'b1, 1'b0);
    fetch_chk(32'd16,         1'b1, NOP,          1'b1, 1'b0);
`endif

    // Full-depth load with implicit last.
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("reload ld_done", 32'(ld_done), 32'd0);
    check("reload inst_valid", 32'(inst_valid), 32'd0);
    check("reload fetch_fault", 32'(fetch_fault), 32'd0);
    check("reload instruction", instruction, NOP);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("ld_ready before final word", 32'(ld_ready), 32'd1);
      load_word(32'hA500_0000 + 32'(i), 1'b0);
    end
    check("full ld_done", 32'(ld_done), 32'd1);
    check("full ld_ready", 32'(ld_ready), 32'd0);
    fetch_chk(32'((DEPTH - 1) * 4), 1'b1, 32'hA500_007F, 1'b1, 1'b0);
    fetch_chk(32'd0,                1'b1, 32'hA500_0000, 1'b1, 1'b0);

    // ld_start together with a fetch: ld_start wins.
    pc = 32'd8; fetch_en = 1'b1; ld_start = 1'b1;
    step();
    ld_start = 1'b0; fetch_en = 1'b0;
    check("start+fetch inst_valid", 32'(inst_valid), 32'd0);
    check("start+fetch instruction", instruction, NOP);
    check("start+fetch ld_done", 32'(ld_done), 32'd0);
    check("start+fetch ld_ready", 32'(ld_ready), 32'd1);

    // ld_start together with a load handshake: the word is dropped.
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
    step();
    ld_start = 1'b0; ld_valid = 1'b0;
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b1);
    check("two-word ld_done", 32'(ld_done), 32'd1);
    fetch_chk(32'd0, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
    fetch_chk(32'd4, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
    fetch_chk(32'd8, 1'b1, NOP,           1'b1, BOUNDS);

    // Asynchronous reset in RUN takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("async rst inst_valid", 32'(inst_valid), 32'd0);
    check("async rst ld_done", 32'(ld_done), 32'd0);
    check("async rst instruction", instruction, NOP);
    check("async rst fetch_fault", 32'(fetch_fault), 32'd0);
    step();
    rst = 1'b0;

    // Reset mid-load: partially loaded words become unreachable.
    load_word(32'h3333_3333, 1'b0);
    load_word(32'h4444_4444, 1'b0);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid-load rst ld_ready", 32'(ld_ready), 32'd1);
    load_word(32'h5555_5555, 1'b1);
    check("post-rst ld_done", 32'(ld_done), 32'd1);
    fetch_chk(32'd4, 1'b1, NOP,           1'b1, BOUNDS);
    fetch_chk(32'd0, 1'b1, 32'h5555_5555, 1'b1, BOUNDS);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
